// File: rtl/axi_lite_fetch_master.sv
// AXI4-Lite read-only fetch initiator: turns core fetch requests into single AR/R transactions.
// Only one transaction is outstanding at a time. A flushed fetch still completes on the bus, and its R beat is discarded.
module axi_lite_fetch_master #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 10,
    parameter logic [2:0] ARPROT     = 3'b100
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state, state_nxt;
    logic                  discard, discard_nxt;
    logic [ADDR_WIDTH-1:0] araddr_nxt;
    logic                  arvalid_nxt;
    logic                  rready_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_data_nxt;
    logic                  rsp_err_nxt;

    assign axi_arprot = ARPROT;
    assign req_ready  = (state == IDLE) || (state == RESP && rsp_ready && !flush);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state       <= IDLE;
            discard     <= 1'b0;
            axi_araddr  <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            axi_araddr  <= araddr_nxt;
            axi_arvalid <= arvalid_nxt;
            axi_rready  <= rready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
            rsp_err     <= rsp_err_nxt;
        end
    end

    // AXI forbids withdrawing arvalid, so a flush only marks the in-flight beat for discarding.
    always_comb begin
        state_nxt     = state;
        discard_nxt   = discard;
        araddr_nxt    = axi_araddr;
        arvalid_nxt   = axi_arvalid;
        rready_nxt    = axi_rready;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid && !flush && !discard) begin
                    araddr_nxt  = req_addr;
                    arvalid_nxt = 1'b1;
                    state_nxt   = ADDR;
                end
            end
            ADDR: begin
                if (flush) begin
                    discard_nxt = 1'b1;
                end
                if (axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (axi_rvalid) begin
                    rready_nxt = 1'b0;
                    if (discard || flush) begin
                        discard_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end else begin
                        rsp_data_nxt  = axi_rdata;
                        rsp_err_nxt   = (axi_rresp != 2'b00);
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = RESP;
                    end
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            RESP: begin
                if (flush) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    if (req_valid) begin
                        araddr_nxt  = req_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = ADDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_fetch_master.sv
// Self-checking bench for axi_lite_fetch_master: directed vector table plus hand-written flush/back-to-back sequences.
// A small AXI4-Lite ROM slave with configurable arready stall and rvalid delay is driven on the falling edge.
module tb_axi_lite_fetch_master;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          axi_aclk    = 1'b0;
    logic          axi_aresetn = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          flush;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] axi_araddr;
    logic [2:0]    axi_arprot;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid;
    logic          axi_rready;

    int assert_count = 0;
    int fail_count   = 0;

    int ar_stall = 0;
    int r_delay  = 0;
    int ar_count;
    int r_count;

    typedef struct {
        logic [AW-1:0] addr;
        int            ar_stall;
        int            r_delay;
        int            rsp_stall;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];
    vec_t after_flush;

    axi_lite_fetch_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ARPROT    (3'b100)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_aresetn(axi_aresetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .axi_araddr (axi_araddr),
        .axi_arprot (axi_arprot),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata  (axi_rdata),
        .axi_rresp  (axi_rresp),
        .axi_rvalid (axi_rvalid),
        .axi_rready (axi_rready)
    );

    always #5 axi_aclk = ~axi_aclk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 10'h004) return 32'hDEADBEEF;
        return {16'hC0DE, 6'b0, a};
    endfunction

    // ROM slave: handshakes are resolved at the falling edge, so they take effect at the next rising edge.
    logic          ar_busy, ar_fire, r_fire, pend;
    int            stall_left, r_wait;
    logic [AW-1:0] pend_addr;

    always @(negedge axi_aclk) begin
        if (!axi_aresetn) begin
            axi_arready = 1'b0;
            axi_rvalid  = 1'b0;
            axi_rdata   = '0;
            axi_rresp   = 2'b00;
            ar_busy     = 1'b0;
            ar_fire     = 1'b0;
            r_fire      = 1'b0;
            pend        = 1'b0;
            pend_addr   = '0;
            stall_left  = 0;
            r_wait      = 0;
            ar_count    = 0;
            r_count     = 0;
        end else begin
            if (ar_fire) begin
                pend   = 1'b1;
                r_wait = r_delay;
            end
            if (r_fire) axi_rvalid = 1'b0;
            if (pend && !axi_rvalid) begin
                if (r_wait == 0) begin
                    axi_rvalid = 1'b1;
                    pend       = 1'b0;
                    if (pend_addr == 10'h3FF) begin
                        axi_rdata = '0;
                        axi_rresp = 2'b10;
                    end else if (pend_addr == 10'h3FE) begin
                        axi_rdata = rom_word(pend_addr);
                        axi_rresp = 2'b11;
                    end else begin
                        axi_rdata = rom_word(pend_addr);
                        axi_rresp = 2'b00;
                    end
                end else begin
                    r_wait--;
                end
            end
            if (axi_arvalid && !ar_busy) begin
                ar_busy    = 1'b1;
                stall_left = ar_stall;
            end
            if (axi_arvalid && stall_left > 0) begin
                axi_arready = 1'b0;
                stall_left--;
            end else begin
                axi_arready = axi_arvalid;
            end
            ar_fire = axi_arvalid && axi_arready;
            if (ar_fire) begin
                ar_busy   = 1'b0;
                pend_addr = axi_araddr;
                ar_count++;
            end
            r_fire = axi_rvalid && axi_rready;
            if (r_fire) r_count++;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives a request at a falling edge; returns at the falling edge of cycle 1.
    task automatic start_req(input logic [AW-1:0] a);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge axi_aclk);
        #1;
        req_valid = 1'b0;
        @(negedge axi_aclk);
    endtask

    // One complete fetch with the configured stalls; checks handshakes, latency and held response.
    task automatic apply_stimulus(input vec_t v);
        int   ar0, r0, cyc, arv_cycles;
        logic seen;
        ar0        = ar_count;
        r0         = r_count;
        ar_stall   = v.ar_stall;
        r_delay    = v.r_delay;
        rsp_ready  = 1'b0;
        arv_cycles = 0;
        seen       = 1'b0;
        check_output("req_ready_idle", 32'(req_ready), 32'd1);
        start_req(v.addr);
        check_output("arvalid_cycle1", 32'(axi_arvalid), 32'd1);
        check_output("araddr_cycle1", 32'(axi_araddr), 32'(v.addr));
        for (cyc = 1; cyc < 60; cyc++) begin
            if (axi_arvalid) begin
                arv_cycles++;
                if (axi_araddr !== v.addr) check_output("araddr_stable", 32'(axi_araddr), 32'(v.addr));
            end
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge axi_aclk);
        end
        check_output("rsp_seen", 32'(seen), 32'd1);
        if (!seen) return;
        check_output("rsp_latency", 32'(cyc), 32'(v.exp_lat));
        check_output("arvalid_held_cycles", 32'(arv_cycles), 32'(v.ar_stall + 1));
        check_output("rsp_data", rsp_data, v.exp_data);
        check_output("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = (v.rsp_stall == 0);
        for (int i = 0; i < v.rsp_stall; i++) begin
            @(negedge axi_aclk);
            check_output("rsp_valid_held", 32'(rsp_valid), 32'd1);
            check_output("rsp_data_held", rsp_data, v.exp_data);
            if (i == v.rsp_stall - 1) rsp_ready = 1'b1;
        end
        @(negedge axi_aclk);
        rsp_ready = 1'b0;
        check_output("rsp_consumed", 32'(rsp_valid), 32'd0);
        check_output("ar_handshakes", 32'(ar_count - ar0), 32'd1);
        check_output("r_handshakes", 32'(r_count - r0), 32'd1);
    endtask

    // After a flushed fetch: no response may surface and exactly one AR and one R handshake must occur.
    task automatic expect_quiet(input string name, input int ar0, input int r0);
        logic bad;
        bad = 1'b0;
        repeat (12) begin
            @(negedge axi_aclk);
            if (rsp_valid) bad = 1'b1;
        end
        check_output({name, "_no_rsp"}, 32'(bad), 32'd0);
        check_output({name, "_ar_count"}, 32'(ar_count - ar0), 32'd1);
        check_output({name, "_r_count"}, 32'(r_count - r0), 32'd1);
        check_output({name, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ar0, r0, got, t_last, next_addr;
        logic accepted;

        vecs[0] = '{10'h004, 0, 0, 0, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{10'h123, 5, 0, 4, 32'hC0DE0123, 1'b0, 8};
        vecs[2] = '{10'h010, 0, 2, 0, 32'hC0DE0010, 1'b0, 5};
        vecs[3] = '{10'h3FF, 0, 0, 1, 32'h00000000, 1'b1, 3};
        vecs[4] = '{10'h0AA, 2, 1, 0, 32'hC0DE00AA, 1'b0, 6};
        vecs[5] = '{10'h3FE, 0, 0, 0, 32'hC0DE03FE, 1'b1, 3};
        vecs[6] = '{10'h000, 0, 0, 0, 32'hC0DE0000, 1'b0, 3};
        after_flush = '{10'h010, 0, 0, 0, 32'hC0DE0010, 1'b0, 3};

        req_valid   = 1'b0;
        req_addr    = '0;
        rsp_ready   = 1'b0;
        flush       = 1'b0;
        axi_aresetn = 1'b0;
        repeat (3) @(negedge axi_aclk);
        check_output("reset_arvalid", 32'(axi_arvalid), 32'd0);
        check_output("reset_rready", 32'(axi_rready), 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_err", 32'(rsp_err), 32'd0);
        check_output("reset_rsp_data", rsp_data, 32'd0);
        check_output("reset_araddr", 32'(axi_araddr), 32'd0);
        check_output("arprot", 32'(axi_arprot), 32'd4);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        check_output("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

        // Back-to-back: request held, response always accepted, one word every three cycles.
        ar_stall  = 0;
        r_delay   = 0;
        got       = 0;
        t_last    = -1;
        next_addr = 0;
        @(posedge axi_aclk);
        #1;
        req_valid = 1'b1;
        req_addr  = '0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            @(negedge axi_aclk);
            if (rsp_valid) begin
                check_output("b2b_data", rsp_data, rom_word(10'(got)));
                check_output("b2b_req_ready", 32'(req_ready), 32'd1);
                got++;
                t_last = cyc;
            end
            accepted = req_valid && req_ready;
            @(posedge axi_aclk);
            #1;
            if (accepted) begin
                next_addr++;
                if (next_addr == 8) req_valid = 1'b0;
                else req_addr = 10'(next_addr);
            end
        end
        @(negedge axi_aclk);
        rsp_ready = 1'b0;
        check_output("b2b_count", 32'(got), 32'd8);
        check_output("b2b_last_cycle", 32'(t_last), 32'd24);
        check_output("b2b_idle", 32'(req_ready), 32'd1);

        // Flush while AR is stalled: arvalid must stay up and the beat is dropped.
        ar0 = ar_count; r0 = r_count;
        ar_stall = 3; r_delay = 0;
        start_req(10'h020);
        @(negedge axi_aclk);
        flush = 1'b1;
        @(negedge axi_aclk);
        flush = 1'b0;
        check_output("flush_addr_arvalid", 32'(axi_arvalid), 32'd1);
        check_output("flush_addr_araddr", 32'(axi_araddr), 32'h020);
        expect_quiet("flush_addr", ar0, r0);
        apply_stimulus(after_flush);

        // Flush in DATA before the beat arrives.
        ar0 = ar_count; r0 = r_count;
        ar_stall = 0; r_delay = 3;
        start_req(10'h030);
        @(negedge axi_aclk);
        check_output("flush_data_rready", 32'(axi_rready), 32'd1);
        flush = 1'b1;
        @(negedge axi_aclk);
        flush = 1'b0;
        expect_quiet("flush_data", ar0, r0);
        apply_stimulus(after_flush);

        // Flush in the same cycle as the AR handshake.
        ar0 = ar_count; r0 = r_count;
        ar_stall = 0; r_delay = 0;
        req_valid = 1'b1;
        req_addr  = 10'h040;
        @(posedge axi_aclk);
        #1;
        req_valid = 1'b0;
        @(negedge axi_aclk);
        flush = 1'b1;
        @(negedge axi_aclk);
        flush = 1'b0;
        check_output("flush_arhs_arvalid", 32'(axi_arvalid), 32'd0);
        check_output("flush_arhs_rready", 32'(axi_rready), 32'd1);
        expect_quiet("flush_arhs", ar0, r0);

        // Flush in the same cycle as the R beat.
        ar0 = ar_count; r0 = r_count;
        start_req(10'h041);
        @(negedge axi_aclk);
        flush = 1'b1;
        @(negedge axi_aclk);
        flush = 1'b0;
        check_output("flush_rbeat_rsp_valid", 32'(rsp_valid), 32'd0);
        expect_quiet("flush_rbeat", ar0, r0);
        apply_stimulus(after_flush);

        // Flush while holding a response: it is dropped and a simultaneous request is ignored.
        ar0 = ar_count; r0 = r_count;
        start_req(10'h050);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        check_output("flush_resp_valid", 32'(rsp_valid), 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'h060;
        #1;
        check_output("flush_resp_req_ready", 32'(req_ready), 32'd0);
        @(negedge axi_aclk);
        flush     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check_output("flush_resp_dropped", 32'(rsp_valid), 32'd0);
        check_output("flush_resp_no_ar", 32'(axi_arvalid), 32'd0);
        expect_quiet("flush_resp", ar0, r0);
        apply_stimulus(after_flush);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
